// File: rtl/mux4x1_8bits_serializer.sv
// ---------------------------------------------------------------------------
// mux4x1_8bits_serializer
//
// Purpose:
//   Takes one group of four lane bytes (each with its own valid bit) and
//   sends them out one byte per clock on a single stream, lane 0 first and
//   lane 3 last. One group can wait in a pending buffer while the previous
//   group is being sent. Offering a new group every 4 cycles therefore keeps
//   the output busy on every cycle.
//
// Ports:
//   clk                   single clock, all state updates on posedge
//   reset                 synchronous, active-high
//   valid_in0..valid_in3  per-lane valid for the offered group
//   data_in0..data_in3    per-lane byte of the offered group
//   in_ready              a group may be accepted at the coming edge
//   valid_out             data_out carries a lane byte this cycle
//   data_out              serialized byte (registered)
//   lane_out              lane index of the current output slot (registered)
//   busy                  serializer is in its SEND state
// ---------------------------------------------------------------------------
module mux4x1_8bits_serializer #(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] IDLE_DATA  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in0,
    input  logic                  valid_in1,
    input  logic                  valid_in2,
    input  logic                  valid_in3,
    input  logic [DATA_WIDTH-1:0] data_in0,
    input  logic [DATA_WIDTH-1:0] data_in1,
    input  logic [DATA_WIDTH-1:0] data_in2,
    input  logic [DATA_WIDTH-1:0] data_in3,
    output logic                  in_ready,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            lane_out,
    output logic                  busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state;
    state_t state_next;
    logic [1:0] slot;
    logic [1:0] slot_next;
    logic       load;
    logic       accept;

    logic [3:0][DATA_WIDTH-1:0] pend_data;
    logic [3:0]                 pend_v;
    logic                       pend_valid;

    logic [3:0][DATA_WIDTH-1:0] act_data;
    logic [3:0]                 act_v;

    logic [3:0] valid_in;

    assign valid_in = {valid_in3, valid_in2, valid_in1, valid_in0};

    // The pending buffer is the only place a new group can land, so it must
    // be empty. Gating with reset keeps a group from being offered as
    // accepted on an edge that discards everything anyway.
    assign in_ready = ~pend_valid & ~reset;
    assign accept   = in_ready & (|valid_in);
    assign busy     = (state == SEND);

    // Next-state logic. A load moves pending into active either from IDLE
    // or on the last slot of a group. Loading on the last slot keeps the
    // stream gapless when groups arrive back to back. The slot counter only
    // restarts through a load; it never counts while idle.
    always_comb begin
        state_next = state;
        slot_next  = slot;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (pend_valid) begin
                    load       = 1'b1;
                    slot_next  = 2'd0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (slot != 2'd3) begin
                    slot_next = slot + 2'd1;
                end else if (pend_valid) begin
                    load      = 1'b1;
                    slot_next = 2'd0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            slot  <= 2'd0;
        end else begin
            state <= state_next;
            slot  <= slot_next;
        end
    end

    // Each lane keeps its own slot even when its valid is low. Output timing
    // therefore does not depend on which lanes are present.
    always_ff @(posedge clk) begin
        if (reset || state == IDLE) begin
            valid_out <= 1'b0;
            data_out  <= IDLE_DATA;
            lane_out  <= 2'd0;
        end else begin
            valid_out <= act_v[slot];
            data_out  <= act_v[slot] ? act_data[slot] : IDLE_DATA;
            lane_out  <= slot;
        end
    end

    // Accept and load never happen on the same edge, because in_ready is
    // low whenever pend_valid is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_data  <= '0;
            pend_v     <= '0;
            pend_valid <= 1'b0;
        end else if (accept) begin
            pend_data  <= {data_in3, data_in2, data_in1, data_in0};
            pend_v     <= valid_in;
            pend_valid <= 1'b1;
        end else if (load) begin
            pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_data <= '0;
            act_v    <= '0;
        end else if (load) begin
            act_data <= pend_data;
            act_v    <= pend_v;
        end
    end

endmodule

// File: doc/mux4x1_8bits_serializer.md
Name: mux4x1_8bits_serializer

Overview:
Inverse of the 1x4 8-bit lane demux. Takes a group of four 8-bit lane bytes (lane0..lane3, each with its own valid) and re-serializes them onto one 8-bit stream at one byte per clock, in ascending lane order. It runs on the single fast clock. It double-buffers one group so that a new group every 4 cycles sustains full output rate.

Parameters:
DATA_WIDTH, 8, width of each lane and of data_out
IDLE_DATA, 8'h00, value driven on data_out whenever valid_out=0

Ports:
clk  input  1  single clock, all state on posedge
reset  input  1  synchronous, active-high
valid_in0..valid_in3  input  1 each  per-lane valid for the offered group
data_in0..data_in3  input  DATA_WIDTH each  per-lane byte
in_ready  output  1  group may be accepted this cycle
valid_out  output  1  data_out carries a lane byte this cycle
data_out  output  DATA_WIDTH  serialized byte (registered)
lane_out  output  2  lane index of the current data_out slot (registered)
busy  output  1  serializer in SEND state

Behaviour:
- Storage:
  - pending buffer: 4 bytes + 4 valid bits + pend_valid flag.
  - active buffer: 4 bytes + 4 valid bits.
  - FSM state IDLE/SEND; 2-bit slot counter.
- in_ready = ~pend_valid & ~reset (combinational from registered pend_valid).
- Accept:
  - A group is accepted at a posedge when in_ready=1 and any valid_inN=1.
  - On accept: pending <= all four bytes and valids; pend_valid <= 1.
  - A group with all four valids low is never accepted; pending is untouched.
- IDLE, each edge:
  - valid_out<=0, data_out<=IDLE_DATA, lane_out<=0.
  - If pend_valid: active<=pending, pend_valid<=0, slot<=0, state<=SEND.
- SEND, each edge with slot s:
  - valid_out<=active_v[s]; data_out<=active_v[s] ? active[s] : IDLE_DATA; lane_out<=s.
  - s<3: slot<=s+1.
  - s==3 and pend_valid: active<=pending, pend_valid<=0, slot<=0, stay SEND (back-to-back, no bubble).
  - s==3 and no pend_valid: state<=IDLE.
- Invalid lanes keep their slot: the slot produces valid_out=0 and no compaction. The output timing of each lane is fixed.
- Latency: group accepted at edge E0 → loaded into active at E1 → lane0 on data_out after E2, lane3 after E5.
- Throughput: pending frees at the load edge, so in_ready is high again the next cycle.
  - One group per 4 cycles gives continuous valid_out=1.
  - Faster offers are back-pressured by in_ready=0.
- No simultaneous accept/load conflict: in_ready=0 whenever pend_valid=1, so a load edge never coincides with an accept.
- busy=1 exactly while state==SEND.
- Reset (synchronous; applies also mid-group):
  - state<=IDLE, slot<=0, pend_valid<=0, active/pending contents<=0.
  - valid_out<=0, data_out<=IDLE_DATA, lane_out<=0, busy<=0.
  - Any in-flight or pending group is discarded with no partial output.
  - in_ready is 0 while reset is high and 1 on the first cycle after release.
- Slot counter wraps 3→0 only via the reload path; it never counts in IDLE.

Test Plan:
- Reset then single group FF,DD,EE,CC (all valid) accepted at E0 → data_out FF,DD,EE,CC with valid_out=1, lane_out 0..3 after E2..E5; then IDLE, valid_out=0, data_out=00.
- Groups {FF,DD,EE,CC} and {BB,99,AA,88} offered every 4 cycles → 8 consecutive valid bytes FF,DD,EE,CC,BB,99,AA,88 with no bubble; in_ready high on each offer cycle.
- Groups offered every cycle (third group 88,88,77,00) → in_ready=0 while pend_valid=1; no group lost or duplicated; output order preserved across all three groups.
- Group with valid_in = {1,0,1,0} (lanes 0..3), data 11,22,33,44 → valid_out 1,0,1,0; data_out 11,00,33,00; lane_out 0,1,2,3.
- All valids low with data 55 → no accept, in_ready stays 1, outputs remain idle.
- Reset asserted after lane1 of group FF,DD,EE,CC with a second group pending → next cycle valid_out=0, busy=0, in_ready=0; after release in_ready=1 and no bytes from either group appear.
